// File: rtl/xprog_port_arb_if.sv
// Bus bundle between the controller/DMA requesters, the port arbiter and
// the program RAM data port.
interface xprog_port_arb_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              ctrl_req;
    logic              ctrl_we;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic              ctrl_gnt;
    logic [DATA_W-1:0] ctrl_rdata;
    logic              ctrl_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
        output ctrl_gnt, ctrl_rdata, ctrl_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
        input  ctrl_gnt, ctrl_rdata, ctrl_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/xprog_port_arb.sv
// Program RAM data-port arbiter: controller has fixed priority, DMA is forced
// ahead after MAX_WAIT blocked cycles; read data is steered back by an owner tag.
module xprog_port_arb #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    xprog_port_arb_if.slave  bus,
    output logic [CNT_W-1:0] conflict_cnt
);
    typedef enum logic {
        OWN_CTRL = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic              ctrl_gnt, dma_gnt, conflict;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [7:0]        starve_q, starve_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              own_valid_q, own_valid_d;
    owner_e            own_id_q, own_id_d;

    always_comb begin
        ctrl_gnt    = 1'b0;
        dma_gnt     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = bus.ctrl_addr;
        mem_wdata   = bus.ctrl_wdata;
        conflict    = bus.ctrl_req & bus.dma_req;
        starve_d    = starve_q;
        cnt_d       = cnt_q;
        own_valid_d = 1'b0;
        own_id_d    = OWN_CTRL;

        if (!rst) begin
            if (bus.dma_req && (!bus.ctrl_req || starve_q == MAX_WAIT_C)) begin
                dma_gnt = 1'b1;
            end else if (bus.ctrl_req) begin
                ctrl_gnt = 1'b1;
            end
        end

        if (dma_gnt) begin
            mem_we    = bus.dma_we;
            mem_addr  = bus.dma_addr;
            mem_wdata = bus.dma_wdata;
        end else if (ctrl_gnt) begin
            mem_we    = bus.ctrl_we;
        end

        // Starvation count holds at MAX_WAIT so the forced slot stays armed.
        if (!bus.dma_req || dma_gnt) begin
            starve_d = '0;
        end else if (starve_q != MAX_WAIT_C) begin
            starve_d = starve_q + 8'd1;
        end

        if (conflict && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        own_valid_d = (ctrl_gnt & ~bus.ctrl_we) | (dma_gnt & ~bus.dma_we);
        own_id_d    = dma_gnt ? OWN_DMA : OWN_CTRL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            cnt_q       <= '0;
            own_valid_q <= 1'b0;
            own_id_q    <= OWN_CTRL;
        end else begin
            starve_q    <= starve_d;
            cnt_q       <= cnt_d;
            own_valid_q <= own_valid_d;
            own_id_q    <= own_id_d;
        end
    end

    assign bus.ctrl_gnt    = ctrl_gnt;
    assign bus.dma_gnt     = dma_gnt;
    assign bus.mem_en      = ctrl_gnt | dma_gnt;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.ctrl_rdata  = bus.mem_rdata;
    assign bus.dma_rdata   = bus.mem_rdata;
    // Gated by rst so a read granted just before reset never reports data.
    assign bus.ctrl_rvalid = own_valid_q & ~rst & (own_id_q == OWN_CTRL);
    assign bus.dma_rvalid  = own_valid_q & ~rst & (own_id_q == OWN_DMA);
    assign conflict_cnt    = cnt_q;
endmodule
